// File: rtl/axi_hdr_pkg.sv
// Shared types and helpers for the header arbiter.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package axi_hdr_pkg;

  localparam int DEF_DATA_WD  = 32;
  localparam int DEF_NUM_SRC  = 4;
  // Widest keep the legality helper accepts; callers zero-extend into it.
  localparam int KEEP_MAX_WD  = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_WAIT_EOP = 2'd2
  } state_e;

  // A header keep must be nonzero and right-aligned contiguous ones.
  // Adding one to such a mask clears every set bit, so the AND is zero.
  function automatic logic keep_is_legal(input logic [KEEP_MAX_WD-1:0] keep);
    return (keep != '0) && ((keep & (keep + 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/axi_stream_header_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_WD-1:0]  ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SRC_WD-1:0]  idx_o,
  output logic               any_o
);

  int                cand;
  logic [SRC_WD-1:0] cand_idx;

  // Walk upward from the pointer and keep the first requester found.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = SRC_WD'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Shares one header-insert port among NUM_SRC producers, round-robin, one header per packet.
// Latency: request consumed combinationally in IDLE; header offered the next cycle.
// Backpressure: header held on valid_insert until ready_insert; grant locked until last_out handshake.
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              valid_req_i,
  input  logic [NUM_SRC*DATA_WD-1:0]      header_req_i,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] keep_req_i,
  output logic [NUM_SRC-1:0]              ready_req_o,
  output logic                            valid_insert_o,
  output logic [DATA_WD-1:0]              header_insert_o,
  output logic [DATA_BYTE_WD-1:0]         keep_insert_o,
  input  logic                            ready_insert_i,
  input  logic                            valid_out_i,
  input  logic                            ready_out_i,
  input  logic                            last_out_i,
  output logic [SRC_WD-1:0]               grant_id_o,
  output logic                            busy_o,
  output logic                            err_keep_o,
  output logic [SRC_WD-1:0]               err_src_o
);

  state_e                  state_q, state_d;
  logic [SRC_WD-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WD-1:0]      header_q, header_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic [SRC_WD-1:0]       grant_q, grant_d;
  logic                    err_keep_q, err_keep_d;
  logic [SRC_WD-1:0]       err_src_q, err_src_d;

  logic [NUM_SRC-1:0]      win_gnt;
  logic [SRC_WD-1:0]       win_idx;
  logic                    win_any;
  logic [DATA_WD-1:0]      win_header;
  logic [DATA_BYTE_WD-1:0] win_keep;
  logic [KEEP_MAX_WD-1:0]  win_keep_ext;
  logic                    eop;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_WD  (SRC_WD)
  ) u_rr (
    .req_i (valid_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign win_header = header_req_i[win_idx*DATA_WD +: DATA_WD];
  assign win_keep   = keep_req_i[win_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign eop        = valid_out_i & ready_out_i & last_out_i;

  // Zero-extend the winner's keep so the shared legality helper can check it.
  always_comb begin
    win_keep_ext                   = '0;
    win_keep_ext[DATA_BYTE_WD-1:0] = win_keep;
  end

  // Next-state, capture and error logic; requests are only consumed in IDLE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    header_d    = header_q;
    keep_d      = keep_q;
    grant_d     = grant_q;
    err_keep_d  = 1'b0;
    err_src_d   = err_src_q;
    ready_req_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          ready_req_o = win_gnt;
          header_d    = win_header;
          keep_d      = win_keep;
          rr_ptr_d    = (win_idx == SRC_WD'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
          if (keep_is_legal(win_keep_ext)) begin
            grant_d = win_idx;
            state_d = ST_OFFER;
          end else begin
            err_keep_d = 1'b1;
            err_src_d  = win_idx;
          end
        end
      end
      ST_OFFER: begin
        if (ready_insert_i) state_d = ST_WAIT_EOP;
      end
      ST_WAIT_EOP: begin
        if (eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      header_q   <= '0;
      keep_q     <= '0;
      grant_q    <= '0;
      err_keep_q <= 1'b0;
      err_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      header_q   <= header_d;
      keep_q     <= keep_d;
      grant_q    <= grant_d;
      err_keep_q <= err_keep_d;
      err_src_q  <= err_src_d;
    end
  end

  assign valid_insert_o  = (state_q == ST_OFFER);
  assign busy_o          = (state_q != ST_IDLE);
  assign header_insert_o = header_q;
  assign keep_insert_o   = keep_q;
  assign grant_id_o      = grant_q;
  assign err_keep_o      = err_keep_q;
  assign err_src_o       = err_src_q;

endmodule
